// File: rtl/jump_control.sv
// ---------------------------------------------------------------------------
// jump_control
//
// Redirect controller on the consumer side of the fetch stage. It decodes the
// instruction word returned by the fetch stage and drives the stage's redirect
// mux (pc_mux_sel / jmp_loc) and its hold input (stall). It handles
// unconditional jumps, flag-conditional jumps, CALL/RET through an internal
// return-address stack, and HLT.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   reset           synchronous, active-high; clears all state
//   ins_pm          instruction word for the address presented one cycle ago
//   current_address address the fetch stage presents to memory this cycle
//   stall_in        downstream hazard stall; suppresses decode this cycle
//   zero_flag       ALU zero flag, aligned with ins_pm
//   carry_flag      ALU carry flag, aligned with ins_pm
//   pc_mux_sel      1 = fetch stage loads jmp_loc this cycle
//   jmp_loc         redirect target
//   stall           holds the fetch stage program counter
//   halted          HLT has been executed
//   stack_err       sticky return-stack overflow/underflow flag
// ---------------------------------------------------------------------------
module jump_control #(
    parameter int ADDR_W      = 8,
    parameter int INS_W       = 20,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INS_W-1:0]  ins_pm,
    input  logic [ADDR_W-1:0] current_address,
    input  logic              stall_in,
    input  logic              zero_flag,
    input  logic              carry_flag,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              halted,
    output logic              stack_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_JZ   = 5'b11001;
    localparam logic [4:0] OP_JNZ  = 5'b11010;
    localparam logic [4:0] OP_JC   = 5'b11011;
    localparam logic [4:0] OP_JNC  = 5'b11100;
    localparam logic [4:0] OP_CALL = 5'b11101;
    localparam logic [4:0] OP_RET  = 5'b11110;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              stack_err_q, stack_err_d;

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_addr;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              dec_en;
    logic              unused_ins_bits;

    assign opcode          = ins_pm[INS_W-1:INS_W-5];
    assign target          = ins_pm[ADDR_W-1:0];
    assign unused_ins_bits = ^ins_pm[INS_W-6:ADDR_W];

    // ins_addr is the address of the word now on ins_pm, so the return
    // address is simply the next sequential address (wraps at the top).
    assign ret_addr = ins_addr_q + ADDR_W'(1);
    assign push_idx = sp_q[PTR_W-1:0];
    assign top_idx  = push_idx - PTR_W'(1);

    assign dec_en = (state_q == ST_RUN) && !stall_in && !reset;

    // Every output reads zero while reset is asserted.
    assign stall     = !reset && ((state_q == ST_HALT) || stall_in);
    assign halted    = !reset && (state_q == ST_HALT);
    assign stack_err = !reset && stack_err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        sp_d        = sp_q;
        stack_d     = stack_q;
        stack_err_d = stack_err_q;
        ins_addr_d  = stall ? ins_addr_q : current_address;
        pc_mux_sel  = 1'b0;
        jmp_loc     = '0;

        if (dec_en) begin
            unique case (opcode)
                OP_JMP: begin
                    pc_mux_sel = 1'b1;
                    jmp_loc    = target;
                end
                OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                    jmp_loc = target;
                    unique case (opcode)
                        OP_JZ:   pc_mux_sel = zero_flag;
                        OP_JNZ:  pc_mux_sel = !zero_flag;
                        OP_JC:   pc_mux_sel = carry_flag;
                        default: pc_mux_sel = !carry_flag;
                    endcase
                    if (!pc_mux_sel) begin
                        jmp_loc = '0;
                    end
                end
                OP_CALL: begin
                    // The call is always taken; only the push is dropped
                    // when the stack is already full.
                    pc_mux_sel = 1'b1;
                    jmp_loc    = target;
                    if (sp_q == SP_FULL) begin
                        stack_err_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = ret_addr;
                        sp_d              = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        stack_err_d = 1'b1;
                    end else begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = stack_q[top_idx];
                        sp_d       = sp_q - SP_W'(1);
                    end
                end
                OP_HLT: begin
                    state_d = ST_HALT;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_RUN;
            ins_addr_q  <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            // NOTE: the stack is a handful of flops, not a RAM macro, so it
            // is cleared on reset to give a known return address state.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ins_addr_q  <= ins_addr_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            stack_q     <= stack_d;
        end
    end

endmodule

// File: tb/tb_jump_control.sv
// ---------------------------------------------------------------------------
// tb_jump_control
//
// Directed bench for jump_control. Each step applies one cycle of inputs just
// after a rising edge and checks outputs on the following falling edge, so
// combinational outputs reflect this step's inputs and registered state
// reflects all earlier steps.
// ---------------------------------------------------------------------------
module tb_jump_control;

    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_JZ   = 5'b11001;
    localparam logic [4:0] OP_JNZ  = 5'b11010;
    localparam logic [4:0] OP_JC   = 5'b11011;
    localparam logic [4:0] OP_JNC  = 5'b11100;
    localparam logic [4:0] OP_CALL = 5'b11101;
    localparam logic [4:0] OP_RET  = 5'b11110;
    localparam logic [4:0] OP_HLT  = 5'b11111;
    localparam logic [19:0] NOP    = 20'h00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] ins_pm = '0;
    logic [7:0]  current_address = '0;
    logic        stall_in = 1'b0;
    logic        zero_flag = 1'b0;
    logic        carry_flag = 1'b0;
    logic        pc_mux_sel;
    logic [7:0]  jmp_loc;
    logic        stall;
    logic        halted;
    logic        stack_err;

    int n_cmp = 0;
    int n_err = 0;

    jump_control #(
        .ADDR_W      (8),
        .INS_W       (20),
        .STACK_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ins_pm          (ins_pm),
        .current_address (current_address),
        .stall_in        (stall_in),
        .zero_flag       (zero_flag),
        .carry_flag      (carry_flag),
        .pc_mux_sel      (pc_mux_sel),
        .jmp_loc         (jmp_loc),
        .stall           (stall),
        .halted          (halted),
        .stack_err       (stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] enc(input logic [4:0] op, input logic [7:0] tgt);
        return {op, 7'b0000000, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [19:0] ins, input logic [7:0] addr,
                        input logic sin, input logic z, input logic c);
        @(posedge clk);
        #1;
        reset           = rst;
        ins_pm          = ins;
        current_address = addr;
        stall_in        = sin;
        zero_flag       = z;
        carry_flag      = c;
        @(negedge clk);
    endtask

    logic [7:0] ret_exp [4];

    initial begin
        ret_exp = '{8'h33, 8'h32, 8'h31, 8'h01};

        // Reset for two cycles with a jump and a stall request present.
        step(1, enc(OP_JMP, 8'h40), 8'h00, 1, 0, 0);
        check("rst_pc",     32'(pc_mux_sel), 0);
        check("rst_jmp",    32'(jmp_loc),    0);
        check("rst_stall",  32'(stall),      0);
        check("rst_halted", 32'(halted),     0);
        check("rst_err",    32'(stack_err),  0);
        step(1, enc(OP_JMP, 8'h40), 8'h00, 1, 0, 0);
        check("rst_sp",     32'(dut.sp_q),   0);
        check("rst_pc2",    32'(pc_mux_sel), 0);

        // Unconditional jump from 0x05.
        step(0, NOP, 8'h05, 0, 0, 0);
        check("nop_pc",    32'(pc_mux_sel), 0);
        check("nop_stall", 32'(stall),      0);
        step(0, enc(OP_JMP, 8'h40), 8'h40, 0, 0, 0);
        check("jmp_addr", 32'(dut.ins_addr_q), 'h05);
        check("jmp_pc",   32'(pc_mux_sel),     1);
        check("jmp_loc",  32'(jmp_loc),        'h40);
        step(0, NOP, 8'h41, 0, 0, 0);
        check("jmp_next_addr", 32'(dut.ins_addr_q), 'h40);
        check("jmp_next_pc",   32'(pc_mux_sel),     0);

        // Conditional jumps.
        step(0, enc(OP_JZ, 8'h20), 8'h42, 0, 0, 0);
        check("jz_nt_pc",  32'(pc_mux_sel), 0);
        check("jz_nt_loc", 32'(jmp_loc),    0);
        step(0, enc(OP_JZ, 8'h20), 8'h20, 0, 1, 0);
        check("jz_t_pc",   32'(pc_mux_sel), 1);
        check("jz_t_loc",  32'(jmp_loc),    'h20);
        step(0, enc(OP_JNC, 8'h30), 8'h21, 0, 0, 1);
        check("jnc_nt_pc", 32'(pc_mux_sel), 0);
        step(0, enc(OP_JNZ, 8'h2A), 8'h2A, 0, 0, 0);
        check("jnz_t_pc",  32'(pc_mux_sel), 1);
        check("jnz_t_loc", 32'(jmp_loc),    'h2A);
        step(0, enc(OP_JC, 8'h3C), 8'h3C, 0, 0, 1);
        check("jc_t_pc",   32'(pc_mux_sel), 1);
        check("jc_t_loc",  32'(jmp_loc),    'h3C);
        step(0, enc(OP_JC, 8'h3C), 8'h3D, 0, 1, 0);
        check("jc_nt_pc",  32'(pc_mux_sel), 0);

        // CALL at 0x10, RET to 0x11.
        step(0, NOP, 8'h10, 0, 0, 0);
        step(0, enc(OP_CALL, 8'h80), 8'h80, 0, 0, 0);
        check("call_addr", 32'(dut.ins_addr_q), 'h10);
        check("call_pc",   32'(pc_mux_sel),     1);
        check("call_loc",  32'(jmp_loc),        'h80);
        check("call_sp0",  32'(dut.sp_q),       0);
        step(0, NOP, 8'h81, 0, 0, 0);
        check("call_sp1",  32'(dut.sp_q),       1);
        step(0, enc(OP_RET, 8'h00), 8'h11, 0, 0, 0);
        check("ret_pc",    32'(pc_mux_sel),     1);
        check("ret_loc",   32'(jmp_loc),        'h11);

        // CALL at 0xFF returns to 0x00.
        step(0, NOP, 8'hFF, 0, 0, 0);
        check("ret_sp0",   32'(dut.sp_q),       0);
        step(0, enc(OP_CALL, 8'h90), 8'h90, 0, 0, 0);
        check("wrap_addr", 32'(dut.ins_addr_q), 'hFF);
        check("wrap_call", 32'(pc_mux_sel),     1);
        step(0, enc(OP_RET, 8'h00), 8'h00, 0, 0, 0);
        check("wrap_sp",   32'(dut.sp_q),       1);
        check("wrap_pc",   32'(pc_mux_sel),     1);
        check("wrap_loc",  32'(jmp_loc),        'h00);

        // Five nested calls; the fifth overflows.
        for (int i = 0; i < 5; i++) begin
            step(0, enc(OP_CALL, 8'(8'h30 + i)), 8'(8'h30 + i), 0, 0, 0);
            check($sformatf("nest%0d_pc", i),  32'(pc_mux_sel), 1);
            check($sformatf("nest%0d_loc", i), 32'(jmp_loc),    32'(8'h30 + i));
            check($sformatf("nest%0d_sp", i),  32'(dut.sp_q),   i);
            check($sformatf("nest%0d_err", i), 32'(stack_err),  0);
        end
        step(0, NOP, 8'h50, 0, 0, 0);
        check("ovf_sp",  32'(dut.sp_q),  4);
        check("ovf_err", 32'(stack_err), 1);

        // Unwind; the dropped fifth push must not appear.
        for (int j = 0; j < 4; j++) begin
            step(0, enc(OP_RET, 8'h00), ret_exp[j], 0, 0, 0);
            check($sformatf("unw%0d_pc", j),  32'(pc_mux_sel), 1);
            check($sformatf("unw%0d_loc", j), 32'(jmp_loc),    32'(ret_exp[j]));
            check($sformatf("unw%0d_sp", j),  32'(dut.sp_q),   4 - j);
        end
        step(0, enc(OP_RET, 8'h00), 8'h02, 0, 0, 0);
        check("udf_sp",  32'(dut.sp_q),  0);
        check("udf_pc",  32'(pc_mux_sel), 0);
        check("udf_loc", 32'(jmp_loc),    0);

        // Reset clears the sticky error; RET on an empty stack sets it.
        step(1, NOP, 8'h03, 0, 0, 0);
        check("rst2_err_out", 32'(stack_err), 0);
        step(0, enc(OP_RET, 8'h00), 8'h07, 0, 0, 0);
        check("rst2_err", 32'(stack_err), 0);
        check("rst2_pc",  32'(pc_mux_sel), 0);
        check("rst2_sp",  32'(dut.sp_q),  0);

        // Stall for three cycles with a CALL on the bus.
        for (int k = 0; k < 3; k++) begin
            step(0, enc(OP_CALL, 8'h50), 8'h08, 1, 0, 0);
            check($sformatf("stl%0d_stall", k), 32'(stall),          1);
            check($sformatf("stl%0d_pc", k),    32'(pc_mux_sel),     0);
            check($sformatf("stl%0d_sp", k),    32'(dut.sp_q),       0);
            check($sformatf("stl%0d_addr", k),  32'(dut.ins_addr_q), 'h07);
            check($sformatf("stl%0d_err", k),   32'(stack_err),      1);
        end
        step(0, enc(OP_CALL, 8'h50), 8'h50, 0, 0, 0);
        check("stl_rel_stall", 32'(stall),      0);
        check("stl_rel_pc",    32'(pc_mux_sel), 1);
        check("stl_rel_loc",   32'(jmp_loc),    'h50);
        step(0, NOP, 8'h51, 0, 0, 0);
        check("stl_rel_sp",    32'(dut.sp_q),   1);
        step(0, enc(OP_RET, 8'h00), 8'h08, 0, 0, 0);
        check("stl_ret_loc",   32'(jmp_loc),    'h08);

        // HLT, then a JMP that must be ignored.
        step(0, NOP, 8'h09, 0, 0, 0);
        step(0, enc(OP_CALL, 8'h60), 8'h60, 0, 0, 0);
        check("pre_hlt_pc", 32'(pc_mux_sel), 1);
        step(0, enc(OP_HLT, 8'h00), 8'h61, 0, 0, 0);
        check("hlt_pc",     32'(pc_mux_sel), 0);
        check("hlt_stall",  32'(stall),      0);
        check("hlt_halted", 32'(halted),     0);
        check("hlt_sp",     32'(dut.sp_q),   1);
        step(0, enc(OP_JMP, 8'h40), 8'h62, 0, 0, 0);
        check("halt_stall",  32'(stall),      1);
        check("halt_halted", 32'(halted),     1);
        check("halt_pc",     32'(pc_mux_sel), 0);
        check("halt_loc",    32'(jmp_loc),    0);
        step(0, enc(OP_JMP, 8'h40), 8'h63, 0, 0, 0);
        check("halt_addr",   32'(dut.ins_addr_q), 'h61);
        check("halt_hold",   32'(halted),         1);

        // Reset while halted, with a CALL on the bus.
        step(1, enc(OP_CALL, 8'h70), 8'h70, 0, 0, 0);
        check("hrst_halted", 32'(halted),     0);
        check("hrst_stall",  32'(stall),      0);
        check("hrst_pc",     32'(pc_mux_sel), 0);
        check("hrst_err",    32'(stack_err),  0);
        step(0, NOP, 8'h00, 0, 0, 0);
        check("post_halted", 32'(halted),    0);
        check("post_stall",  32'(stall),     0);
        check("post_err",    32'(stack_err), 0);
        check("post_sp",     32'(dut.sp_q),  0);
        step(0, enc(OP_JMP, 8'h44), 8'h44, 0, 0, 0);
        check("post_jmp_pc",  32'(pc_mux_sel), 1);
        check("post_jmp_loc", 32'(jmp_loc),    'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
